io_ring_pwr_seq: RTL and testbench

//  Digital power-up/down sequencer for the EG 3.3V IO ring, upstream of the VPW/VDDIO supply pad cells.

---
 rtl/io_ring_pwr_seq_pkg.sv | 18 +
 rtl/io_ring_pwr_seq_pg_sync.sv | 31 +++
 rtl/io_ring_pwr_seq.sv | 240 ++++++++++++++++++++++++
 tb/tb_io_ring_pwr_seq.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/io_ring_pwr_seq_pkg.sv
// io_ring_pkg: shared types for the EG 3.3V IO-ring power sequencer.
// State encodings are visible on seq_state_o, so the numeric values are fixed.
package io_ring_pkg;

    localparam int SEQ_STATE_W = 3;

    typedef enum logic [SEQ_STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_PG  = 3'd1,
        ST_DEBOUNCE = 3'd2,
        ST_REL_RET  = 3'd3,
        ST_REL_ISO  = 3'd4,
        ST_READY    = 3'd5,
        ST_SHUTDOWN = 3'd6,
        ST_FAULT    = 3'd7
    } io_seq_state_e;

endpackage

// File: rtl/io_ring_pwr_seq_pg_sync.sv
// io_pg_sync: multi-flop synchroniser that brings the asynchronous VDDIO
// power-good flag into the core clock domain. It clears to 0 on reset so
// the sequencer treats the supply as absent until it has been observed.
module io_pg_sync
    import io_ring_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the raw flag one stage per clock; only the last stage is used.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_i};
    end

    // Synchroniser flops, synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= sync_d;
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/io_ring_pwr_seq.sv
// io_ring_pwr_seq: power-up/down sequencer for the EG 3.3V IO ring.
// Power-up releases retention, then isolation, then output enables; power-down
// (shutdown pulse or loss of power-good) reverses that order.
// Optional feature macro: IO_PWR_SEQ_TIMEOUT_EN adds a WAIT_PG/DEBOUNCE
// timeout that parks the block in a sticky FAULT state until reset.
module io_ring_pwr_seq
    import io_ring_pkg::*;
#(
    parameter int PG_SYNC_STAGES = 2,
    parameter int DEBOUNCE_CYC   = 16,
    parameter int RET_DLY_CYC    = 8,
    parameter int ISO_DLY_CYC    = 32,
    parameter int TIMEOUT_CYC    = 4096,
    parameter int CNT_W          = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pwr_good_async_i,
    input  logic                   seq_start_i,
    input  logic                   seq_shutdown_i,
    output logic                   pad_ret_o,
    output logic                   pad_iso_o,
    output logic                   pad_oe_en_o,
    output logic                   seq_ready_o,
    output logic [SEQ_STATE_W-1:0] seq_state_o,
    output logic                   fault_o
);

    // Terminal counts: a wait of N cycles ends when the counter reads N-1.
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] RET_LAST = CNT_W'(RET_DLY_CYC - 1);
    localparam logic [CNT_W-1:0] ISO_LAST = CNT_W'(ISO_DLY_CYC - 1);

    // Zero delays would collapse the ordering guarantees; refuse to build.
    if (PG_SYNC_STAGES < 2 || DEBOUNCE_CYC < 1 || RET_DLY_CYC < 1 ||
        ISO_DLY_CYC < 1 || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("io_ring_pwr_seq: illegal zero delay or synchroniser depth < 2");
    end
    if (DEBOUNCE_CYC >= 2**CNT_W || RET_DLY_CYC >= 2**CNT_W ||
        ISO_DLY_CYC >= 2**CNT_W || TIMEOUT_CYC >= 2**CNT_W) begin : g_bad_cnt_w
        $error("io_ring_pwr_seq: CNT_W too narrow for configured delays");
    end

    logic pg_s;

    io_pg_sync #(
        .STAGES (PG_SYNC_STAGES)
    ) u_pg_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (pwr_good_async_i),
        .q_o   (pg_s)
    );

    io_seq_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             ret_q, ret_d;
    logic             iso_q, iso_d;
    logic             oe_q, oe_d;
    logic             rdy_q, rdy_d;
    logic             tmo_hit;

    // Delay counter saturates at all-ones instead of wrapping.
    always_comb begin
        cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    end

`ifdef IO_PWR_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic             fault_q, fault_d;
    logic             in_pg_wait;

    // Timeout counter runs only while waiting for a stable supply.
    always_comb begin
        in_pg_wait = (state_q == ST_WAIT_PG) || (state_q == ST_DEBOUNCE);
        tmo_hit    = in_pg_wait && (tmo_q == TMO_LAST);
        tmo_d      = '0;
        if (in_pg_wait) tmo_d = tmo_hit ? tmo_q : tmo_q + CNT_W'(1);
        fault_d    = fault_q | (state_d == ST_FAULT);
    end

    // Timeout counter and sticky fault flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            tmo_q   <= tmo_d;
            fault_q <= fault_d;
        end
    end

    assign fault_o = fault_q;
`else
    assign tmo_hit = 1'b0;
    assign fault_o = 1'b0;
`endif

    // Next-state and registered-output decode; outputs change only on
    // transitions so the ret -> iso -> oe order is enforced by the state path.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ret_d   = ret_q;
        iso_d   = iso_q;
        oe_d    = oe_q;
        rdy_d   = rdy_q;

        unique case (state_q)
            ST_IDLE: begin
                if (seq_start_i) begin
                    state_d = ST_WAIT_PG;
                    cnt_d   = '0;
                end
            end

            ST_WAIT_PG: begin
                if (seq_shutdown_i) begin
                    state_d = ST_SHUTDOWN;
                    cnt_d   = '0;
                end else if (tmo_hit) begin
                    state_d = ST_FAULT;
                end else if (pg_s) begin
                    state_d = ST_DEBOUNCE;
                    cnt_d   = '0;
                end
            end

            ST_DEBOUNCE: begin
                if (seq_shutdown_i) begin
                    state_d = ST_SHUTDOWN;
                    cnt_d   = '0;
                end else if (tmo_hit) begin
                    state_d = ST_FAULT;
                end else if (!pg_s) begin
                    // A glitch restarts the whole debounce window.
                    state_d = ST_WAIT_PG;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ST_REL_RET;
                    cnt_d   = '0;
                    ret_d   = 1'b0;
                end else begin
                    cnt_d   = cnt_inc;
                end
            end

            ST_REL_RET: begin
                if (seq_shutdown_i || !pg_s) begin
                    state_d = ST_SHUTDOWN;
                    cnt_d   = '0;
                end else if (cnt_q == RET_LAST) begin
                    state_d = ST_REL_ISO;
                    cnt_d   = '0;
                    iso_d   = 1'b0;
                end else begin
                    cnt_d   = cnt_inc;
                end
            end

            ST_REL_ISO: begin
                if (seq_shutdown_i || !pg_s) begin
                    state_d = ST_SHUTDOWN;
                    cnt_d   = '0;
                end else if (cnt_q == ISO_LAST) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                    oe_d    = 1'b1;
                    rdy_d   = 1'b1;
                end else begin
                    cnt_d   = cnt_inc;
                end
            end

            ST_READY: begin
                if (seq_shutdown_i || !pg_s) begin
                    state_d = ST_SHUTDOWN;
                    cnt_d   = '0;
                    oe_d    = 1'b0;
                    rdy_d   = 1'b0;
                end
            end

            ST_SHUTDOWN: begin
                // Drivers are already off on entry; clamp next, then retain.
                oe_d  = 1'b0;
                rdy_d = 1'b0;
                iso_d = 1'b1;
                if (cnt_q == '0) begin
                    cnt_d   = CNT_W'(1);
                end else begin
                    ret_d   = 1'b1;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end

            ST_FAULT: begin
                ret_d = 1'b1;
                iso_d = 1'b1;
                oe_d  = 1'b0;
                rdy_d = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and output registers; reset parks the ring in its safe state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ret_q   <= 1'b1;
            iso_q   <= 1'b1;
            oe_q    <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ret_q   <= ret_d;
            iso_q   <= iso_d;
            oe_q    <= oe_d;
            rdy_q   <= rdy_d;
        end
    end

    assign pad_ret_o   = ret_q;
    assign pad_iso_o   = iso_q;
    assign pad_oe_en_o = oe_q;
    assign seq_ready_o = rdy_q;
    assign seq_state_o = state_q;

endmodule

// File: tb/tb_io_ring_pwr_seq.sv
// Scoreboard bench for io_ring_pwr_seq: stimulus pushes cycle-tagged expected
// output vectors {state, ret, iso, oe, ready, fault}; a negedge monitor pops
// and compares them and also checks the pad ordering invariants every cycle.
// The timeout scenario is compiled in when IO_PWR_SEQ_TIMEOUT_EN is defined.
module tb_io_ring_pwr_seq;
    import io_ring_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pg = 1'b0;
    logic       start = 1'b0;
    logic       sd = 1'b0;
    logic       pad_ret, pad_iso, pad_oe, ready, fault;
    logic [2:0] state;

    io_ring_pwr_seq dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pwr_good_async_i (pg),
        .seq_start_i      (start),
        .seq_shutdown_i   (sd),
        .pad_ret_o        (pad_ret),
        .pad_iso_o        (pad_iso),
        .pad_oe_en_o      (pad_oe),
        .seq_ready_o      (ready),
        .seq_state_o      (state),
        .fault_o          (fault)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         c;
        string      nm;
        logic [7:0] e;
    } chk_t;

    chk_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   chk_inv = 1'b0;

    logic [7:0] act;
    assign act = {state, pad_ret, pad_iso, pad_oe, ready, fault};

    function automatic logic [7:0] pk(int st, bit r, bit i, bit o, bit y, bit f);
        logic [2:0] s;
        s = st[2:0];
        return {s, r, i, o, y, f};
    endfunction

    task automatic push(int c, string nm, logic [7:0] e);
        chk_t t;
        t.c = c; t.nm = nm; t.e = e;
        q.push_back(t);
    endtask

    task automatic at_cyc(int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Expected power-up trace, X = edge at which DEBOUNCE is entered.
    task automatic expect_powerup(int x);
        push(x,      "deb_entry", pk(2, 1, 1, 0, 0, 0));
        push(x + 15, "deb_last",  pk(2, 1, 1, 0, 0, 0));
        push(x + 16, "ret_fall",  pk(3, 0, 1, 0, 0, 0));
        push(x + 23, "ret_wait",  pk(3, 0, 1, 0, 0, 0));
        push(x + 24, "iso_fall",  pk(4, 0, 0, 0, 0, 0));
        push(x + 55, "iso_wait",  pk(4, 0, 0, 0, 0, 0));
        push(x + 56, "ready",     pk(5, 0, 0, 1, 1, 0));
    endtask

    // Monitor: compare due expectations and the ordering invariants.
    always @(negedge clk) begin
        for (int i = int'(q.size()) - 1; i >= 0; i--) begin
            if (q[i].c <= cyc) begin
                n_tests++;
                if (q[i].c < cyc || act !== q[i].e) begin
                    n_fail++;
                    $display("FAIL %s @cyc %0d: got st/ret/iso/oe/rdy/flt=%b want %b",
                             q[i].nm, cyc, act, q[i].e);
                end
                q.delete(i);
            end
        end
        if (chk_inv) begin
            n_tests++;
            if ((pad_oe && pad_iso) || (!pad_iso && pad_ret) ||
                $isunknown({pad_oe, pad_iso, pad_ret})) begin
                n_fail++;
                $display("FAIL invariant @cyc %0d: oe=%b iso=%b ret=%b", cyc, pad_oe, pad_iso, pad_ret);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int x, r, c0, n, end_c;

        // Reset state
        push(2, "reset_a", pk(0, 1, 1, 0, 0, 0));
        push(3, "reset_b", pk(0, 1, 1, 0, 0, 0));
        at_cyc(2);
        chk_inv = 1'b1;
        at_cyc(3);
        rst_n = 1'b1;
        push(6, "idle_hold", pk(0, 1, 1, 0, 0, 0));

        // 1: start with pg rising; pg_s needs two sync edges before WAIT_PG sees it
        at_cyc(7);
        pg = 1'b1; start = 1'b1;
        x = 10;
        push(8, "wait_pg", pk(1, 1, 1, 0, 0, 0));
        expect_powerup(x);
        at_cyc(8);
        start = 1'b0;
        // start outside IDLE is ignored
        at_cyc(x + 18);
        start = 1'b1;
        push(x + 19, "start_ignored", pk(3, 0, 1, 0, 0, 0));
        at_cyc(x + 19);
        start = 1'b0;

        // 3: shutdown pulse from READY
        r = x + 58;
        at_cyc(r);
        sd = 1'b1;
        push(r + 1, "sd_oe_off",  pk(6, 0, 0, 0, 0, 0));
        push(r + 2, "sd_iso_on",  pk(6, 0, 1, 0, 0, 0));
        push(r + 3, "sd_ret_on",  pk(0, 1, 1, 0, 0, 0));
        at_cyc(r + 1);
        sd = 1'b0;

        // 2: pg glitch during debounce (pg_s already high at start)
        c0 = r + 5;
        at_cyc(c0);
        start = 1'b1;
        x = c0 + 2;
        push(x,      "g_deb_entry", pk(2, 1, 1, 0, 0, 0));
        push(x + 10, "g_deb_cnt10", pk(2, 1, 1, 0, 0, 0));
        push(x + 11, "g_back_wait", pk(1, 1, 1, 0, 0, 0));
        expect_powerup(x + 12);
        at_cyc(c0 + 1);
        start = 1'b0;
        at_cyc(x + 8);
        pg = 1'b0;
        at_cyc(x + 9);
        pg = 1'b1;
        x = x + 12;

        // 4: brown-out from READY
        r = x + 58;
        at_cyc(r);
        pg = 1'b0;
        push(r + 2, "bo_sync_dly", pk(5, 0, 0, 1, 1, 0));
        push(r + 3, "bo_oe_off",   pk(6, 0, 0, 0, 0, 0));
        push(r + 4, "bo_iso_on",   pk(6, 0, 1, 0, 0, 0));
        push(r + 5, "bo_ret_on",   pk(0, 1, 1, 0, 0, 0));
        at_cyc(r + 6);
        pg = 1'b1;

        // 5: reset pulse during REL_ISO
        c0 = r + 8;
        at_cyc(c0);
        start = 1'b1;
        x = c0 + 2;
        n = x + 30;
        push(x,      "r_deb_entry", pk(2, 1, 1, 0, 0, 0));
        push(x + 24, "r_rel_iso",   pk(4, 0, 0, 0, 0, 0));
        push(n,      "r_pre_rst",   pk(4, 0, 0, 0, 0, 0));
        push(n + 1,  "r_rst_vals",  pk(0, 1, 1, 0, 0, 0));
        push(n + 3,  "r_idle",      pk(0, 1, 1, 0, 0, 0));
        at_cyc(c0 + 1);
        start = 1'b0;
        at_cyc(n);
        rst_n = 1'b0;
        at_cyc(n + 1);
        rst_n = 1'b1;
        end_c = n + 3;

`ifdef IO_PWR_SEQ_TIMEOUT_EN
        // 6: timeout with pg held low
        at_cyc(n + 2);
        pg = 1'b0;
        c0 = n + 6;
        at_cyc(c0);
        start = 1'b1;
        push(c0 + 1 + 4095, "t_pre_fault",  pk(1, 1, 1, 0, 0, 0));
        push(c0 + 1 + 4096, "t_fault",      pk(7, 1, 1, 0, 0, 1));
        push(c0 + 1 + 4102, "t_start_ign",  pk(7, 1, 1, 0, 0, 1));
        push(c0 + 1 + 4105, "t_rst_clear",  pk(0, 1, 1, 0, 0, 0));
        at_cyc(c0 + 1);
        start = 1'b0;
        at_cyc(c0 + 1 + 4100);
        start = 1'b1;
        at_cyc(c0 + 1 + 4101);
        start = 1'b0;
        at_cyc(c0 + 1 + 4104);
        rst_n = 1'b0;
        at_cyc(c0 + 1 + 4105);
        rst_n = 1'b1;
        end_c = c0 + 1 + 4105;
`endif

        at_cyc(end_c + 3);
        foreach (q[i]) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: expected at cyc %0d never compared", q[i].nm, q[i].c);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
